// File: rtl/sinc_arbiter_pkg.sv
// Shared constants and FSM state encoding for the SINC arbiter.
package sinc_arbiter_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned ID_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sinc_arbiter_sinc.sv
// SINC incrementer: signed op + 1 with wrap-around and overflow flag.
module sinc_arbiter_sinc #(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] i_op,
    output logic [DATAWIDTH-1:0] o_sum_c,
    output logic                 o_ovf_c
);

    localparam logic [DATAWIDTH-1:0] MAX_POS = {1'b0, {(DATAWIDTH-1){1'b1}}};

    assign o_sum_c = i_op + DATAWIDTH'(1);
    // Only the largest positive value overflows when adding one
    assign o_ovf_c = (i_op == MAX_POS);

endmodule

// File: rtl/sinc_arbiter.sv
// Round-robin arbiter sharing one SINC incrementer among four requesters.
module sinc_arbiter
    import sinc_arbiter_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_bus,
    output logic [NREQ-1:0]           gnt,
    output logic [DATAWIDTH-1:0]      d,
    output logic [ID_W-1:0]           d_id,
    output logic                      d_valid,
    output logic                      ovf,
    input  logic                      d_ack
);

    state_t                r_state, w_state_nxt;
    logic [ID_W-1:0]       r_ptr, w_ptr_nxt;
    logic [DATAWIDTH-1:0]  r_op, w_op_nxt;
    logic [ID_W-1:0]       r_id, w_id_nxt;
    logic [NREQ-1:0]       r_gnt, w_gnt_nxt;
    logic [DATAWIDTH-1:0]  r_d, w_d_nxt;
    logic [ID_W-1:0]       r_d_id, w_d_id_nxt;
    logic                  r_d_valid, w_d_valid_nxt;
    logic                  r_ovf, w_ovf_nxt;

    logic                  w_win_found;
    logic [ID_W-1:0]       w_win;
    logic [DATAWIDTH-1:0]  w_op_sel;
    logic [DATAWIDTH-1:0]  w_sum;
    logic                  w_ovf;

    // First requesting index at or after the pointer, wrapping modulo NREQ
    always_comb begin
        w_win_found = 1'b0;
        w_win       = r_ptr;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_win_found && req[r_ptr + ID_W'(i)]) begin
                w_win_found = 1'b1;
                w_win       = r_ptr + ID_W'(i);
            end
        end
    end

    assign w_op_sel = a_bus[32'(w_win) * DATAWIDTH +: DATAWIDTH];

    sinc_arbiter_sinc #(
        .DATAWIDTH (DATAWIDTH)
    ) u_sinc (
        .i_op    (r_op),
        .o_sum_c (w_sum),
        .o_ovf_c (w_ovf)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_op_nxt      = r_op;
        w_id_nxt      = r_id;
        w_gnt_nxt     = '0;
        w_d_nxt       = r_d;
        w_d_id_nxt    = r_d_id;
        w_d_valid_nxt = r_d_valid;
        w_ovf_nxt     = r_ovf;
        case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_op_nxt    = w_op_sel;
                    w_id_nxt    = w_win;
                    w_gnt_nxt   = NREQ'(1) << w_win;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_d_nxt       = w_sum;
                w_d_id_nxt    = r_id;
                w_ovf_nxt     = w_ovf;
                w_d_valid_nxt = 1'b1;
                w_state_nxt   = DONE;
            end
            DONE: begin
                if (d_ack) begin
                    w_d_valid_nxt = 1'b0;
                    w_ovf_nxt     = 1'b0;
                    w_ptr_nxt     = r_id + ID_W'(1);
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_op      <= '0;
            r_id      <= '0;
            r_gnt     <= '0;
            r_d       <= '0;
            r_d_id    <= '0;
            r_d_valid <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_op      <= w_op_nxt;
            r_id      <= w_id_nxt;
            r_gnt     <= w_gnt_nxt;
            r_d       <= w_d_nxt;
            r_d_id    <= w_d_id_nxt;
            r_d_valid <= w_d_valid_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign d       = r_d;
    assign d_id    = r_d_id;
    assign d_valid = r_d_valid;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_sinc_arbiter.sv
// Scoreboard bench for sinc_arbiter: transaction-level model plus negedge monitor.
module tb_sinc_arbiter;

    localparam int DW = 8;

    logic          Clk;
    logic          Rst;
    logic [3:0]    req;
    logic [4*DW-1:0] a_bus;
    logic [3:0]    gnt;
    logic [DW-1:0] d;
    logic [1:0]    d_id;
    logic          d_valid;
    logic          ovf;
    logic          d_ack;

    sinc_arbiter #(.DATAWIDTH(DW)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .req     (req),
        .a_bus   (a_bus),
        .gnt     (gnt),
        .d       (d),
        .d_id    (d_id),
        .d_valid (d_valid),
        .ovf     (ovf),
        .d_ack   (d_ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int            id;
        logic [DW-1:0] d;
        logic          ovf;
    } res_t;

    res_t       rq[$];
    logic [3:0] gq[$];
    int         glog[$];
    int         total;
    int         bad;
    bit         mon_en;
    logic [3:0] reraise;
    bit         auto_rr;

    bit m_busy, m_vis;
    int m_ptr, m_id, m_age;

    logic [7:0] t_op[3];
    logic [7:0] t_d[3];
    logic       t_ovf[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: one transaction at a time, cyclic search from the pointer,
    // result visible one cycle after the grant until acknowledged.
    always @(posedge Clk) begin : model
        int w;
        int s;
        logic signed [DW-1:0] a;
        res_t r;
        if (Rst) begin
            m_busy = 0; m_vis = 0; m_ptr = 0; m_age = 0; m_id = 0;
            gq.delete();
            rq.delete();
        end else if (!m_busy) begin
            if (req != 4'b0) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                a = a_bus[w*DW +: DW];
                s = int'(a) + 1;
                r.ovf = (s > 127);
                if (s > 127) s = s - 256;
                r.d  = s[DW-1:0];
                r.id = w;
                gq.push_back(4'b0001 << w);
                rq.push_back(r);
                m_busy = 1; m_age = 0; m_id = w;
            end
        end else begin
            m_age++;
            if (m_age == 1) m_vis = 1;
            else if (d_ack) begin
                m_vis = 0; m_busy = 0; m_ptr = (m_id + 1) % 4;
            end
        end
    end

    logic [3:0]    p_gnt;
    logic          p_dv;
    logic [DW-1:0] p_d;
    logic [1:0]    p_id;
    logic          p_ovf;

    always @(negedge Clk) begin : monitor
        logic [3:0] eg;
        res_t r;
        if (mon_en) begin
            eg = 4'b0;
            if (gq.size() != 0) eg = gq.pop_front();
            chk("gnt", 32'(gnt), 32'(eg));
            if (gnt != 4'b0) begin
                chk("gnt_pulse", 32'(p_gnt), 32'(0));
                for (int i = 0; i < 4; i++) if (gnt[i]) glog.push_back(i);
            end
            chk("d_valid", 32'(d_valid), 32'(m_vis));
            if (d_valid && !p_dv) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL result_unexpected: got id %0d want none", d_id);
                end else begin
                    r = rq.pop_front();
                    chk("d", 32'(d), 32'(r.d));
                    chk("d_id", 32'(d_id), 32'(r.id));
                    chk("ovf", 32'(ovf), 32'(r.ovf));
                end
            end else if (d_valid && p_dv) begin
                chk("hold_d", 32'(d), 32'(p_d));
                chk("hold_id", 32'(d_id), 32'(p_id));
                chk("hold_ovf", 32'(ovf), 32'(p_ovf));
            end
        end
        p_gnt = gnt; p_dv = d_valid; p_d = d; p_id = d_id; p_ovf = ovf;
    end

    // Requesters drop req when granted; optionally re-raise one cycle later.
    task automatic cyc();
        @(negedge Clk);
        req     = (req & ~gnt) | reraise;
        reraise = auto_rr ? gnt : 4'b0;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] v);
        a_bus[i*DW +: DW] = v;
    endtask

    task automatic wait_dv();
        int n;
        n = 0;
        while (!d_valid && n < 20) begin cyc(); n++; end
        if (!d_valid) begin
            total++; bad++;
            $display("FAIL wait_dv: got d_valid=0 want 1 within 20 cycles");
        end
    endtask

    task automatic ack();
        d_ack = 1'b1;
        cyc();
        d_ack = 1'b0;
    endtask

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0: return 8'h7F;
            1: return 8'hFF;
            2: return 8'h80;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        total = 0; bad = 0; mon_en = 0;
        Rst = 1'b1; req = 4'b0; a_bus = '0; d_ack = 1'b0;
        reraise = 4'b0; auto_rr = 0;
        t_op[0] = 8'h7F; t_d[0] = 8'h80; t_ovf[0] = 1'b1;
        t_op[1] = 8'hFF; t_d[1] = 8'h00; t_ovf[1] = 1'b0;
        t_op[2] = 8'h80; t_d[2] = 8'h81; t_ovf[2] = 1'b0;

        repeat (2) @(negedge Clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_d", 32'(d), 0);
        chk("rst_d_id", 32'(d_id), 0);
        chk("rst_d_valid", 32'(d_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        Rst = 1'b0;
        mon_en = 1;

        // Single requester 2, operand 5
        glog.delete();
        set_op(2, 8'd5); req = 4'b0100;
        wait_dv();
        chk("t1_gnt_id", 32'(glog[0]), 2);
        repeat (3) cyc();
        chk("t1_d", 32'(d), 6);
        chk("t1_d_id", 32'(d_id), 2);
        chk("t1_ovf", 32'(ovf), 0);
        chk("t1_d_valid", 32'(d_valid), 1);
        ack();
        chk("t1_after_ack", 32'(d_valid), 0);

        // Arithmetic boundaries on requester 0
        for (int i = 0; i < 3; i++) begin
            set_op(0, t_op[i]); req = 4'b0001;
            wait_dv();
            chk("t2_d", 32'(d), 32'(t_d[i]));
            chk("t2_ovf", 32'(ovf), 32'(t_ovf[i]));
            ack();
        end

        // Serve id 1, then 1001 together: 3 before 0
        set_op(1, 8'd10); req = 4'b0010;
        wait_dv(); ack();
        glog.delete();
        set_op(3, 8'd20); set_op(0, 8'd30); req = 4'b1001;
        d_ack = 1'b1;
        repeat (12) cyc();
        d_ack = 1'b0;
        chk("t3_count", 32'(glog.size()), 2);
        chk("t3_first", 32'(glog[0]), 3);
        chk("t3_second", 32'(glog[1]), 0);

        // Consumer stall with a pending request
        set_op(0, 8'd50); req = 4'b0001;
        wait_dv();
        set_op(1, 8'd60); req = 4'b0010;
        glog.delete();
        repeat (5) begin
            cyc();
            chk("t4_stall_gnt", 32'(gnt), 0);
            chk("t4_stall_dv", 32'(d_valid), 1);
            chk("t4_stall_id", 32'(d_id), 0);
        end
        ack();
        wait_dv();
        chk("t4_next_gnt", 32'(glog[0]), 1);
        chk("t4_next_id", 32'(d_id), 1);
        ack();

        // All four requesting continuously from reset
        Rst = 1'b1; cyc(); Rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1));
        glog.delete();
        auto_rr = 1; d_ack = 1'b1; req = 4'b1111;
        repeat (16) cyc();
        auto_rr = 0;
        n = 0;
        while ((req != 4'b0 || reraise != 4'b0 || d_valid) && n < 40) begin cyc(); n++; end
        d_ack = 1'b0;
        chk("t5_count_ge5", 32'(glog.size() >= 5), 1);
        chk("t5_g0", 32'(glog[0]), 0);
        chk("t5_g1", 32'(glog[1]), 1);
        chk("t5_g2", 32'(glog[2]), 2);
        chk("t5_g3", 32'(glog[3]), 3);
        chk("t5_g4", 32'(glog[4]), 0);

        // Reset during DONE abandons the result and rewinds the pointer
        repeat (2) cyc();
        set_op(1, 8'd7); req = 4'b0010;
        wait_dv(); ack();
        set_op(2, 8'd8); req = 4'b0100;
        wait_dv();
        Rst = 1'b1; cyc(); Rst = 1'b0;
        chk("t6_rst_dv", 32'(d_valid), 0);
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_d", 32'(d), 0);
        glog.delete();
        set_op(0, 8'd9); set_op(2, 8'd11); req = 4'b0101;
        d_ack = 1'b1;
        repeat (10) cyc();
        d_ack = 1'b0;
        chk("t6_count", 32'(glog.size()), 2);
        chk("t6_first", 32'(glog[0]), 0);
        chk("t6_second", 32'(glog[1]), 2);

        // Random traffic with random acks and occasional resets
        for (int c = 0; c < 3000; c++) begin
            cyc();
            Rst   = ($urandom_range(0, 299) == 0);
            d_ack = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && !gnt[i] && $urandom_range(0, 3) == 0) begin
                    set_op(i, pick_operand());
                    req[i] = 1'b1;
                end
            end
        end
        Rst = 1'b0;
        d_ack = 1'b1;
        n = 0;
        while ((req != 4'b0 || d_valid || gq.size() != 0) && n < 100) begin cyc(); n++; end
        repeat (3) cyc();
        chk("drain_req", 32'(req), 0);
        chk("drain_dv", 32'(d_valid), 0);
        chk("drain_rq", 32'(rq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sinc_arbiter.md
SINC_ARBITER -- requirements
Module: sinc_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 8, operand/result width in bits (signed, two's complement).
REQ-002 Parameter NREQ, fixed at 4, number of requesters sharing the incrementer.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset; synchronous and active-high.
REQ-005 req  input  4  request vector, bit i = requester i wants an increment.
REQ-006 a_bus  input  4*DATAWIDTH  operands; requester i operand = a_bus[i*DATAWIDTH +: DATAWIDTH], signed.
REQ-007 gnt  output  4  registered one-hot grant; all-zero when no grant.
REQ-008 d  output  DATAWIDTH  registered signed result.
REQ-009 d_id  output  2  registered index of the requester that owns d.
REQ-010 d_valid  output  1  registered; result d/d_id/ovf is valid.
REQ-011 ovf  output  1  registered; set with d_valid when signed overflow occurred.
REQ-012 d_ack  input  1  consumer accepts result; meaningful only while d_valid=1.

Function
REQ-013 FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-014 IDLE: if req != 0, select winner w = first set bit of req searching cyclically from ptr (ptr, ptr+1, ... mod 4); latch op <= operand w, id <= w; next state BUSY; else stay IDLE.
REQ-015 BUSY (exactly 1 cycle): gnt = one-hot(id); d <= op + 1 truncated to DATAWIDTH; d_id <= id; ovf <= (op == 2^(DATAWIDTH-1)-1); d_valid <= 1; next state DONE.
REQ-016 DONE: gnt = 0; d, d_id, ovf, d_valid held stable until d_ack=1; on d_ack: d_valid <= 0, ovf <= 0, ptr <= id+1 mod 4, next state IDLE.
REQ-017 Latency: req sampled at edge k -> gnt high in cycle k+1 -> d_valid high from cycle k+2; minimum 3 cycles per transaction.
REQ-018 Requester contract: hold req and operand stable until gnt seen; deassert req the cycle after gnt. Arbiter SHALL NOT re-sample req outside IDLE.
REQ-019 Arithmetic: signed wrap-around, no saturation; max positive + 1 yields most-negative value with ovf=1; -1 + 1 yields 0 with ovf=0.
REQ-020 req changes while in BUSY/DONE SHALL be ignored; no more than one transaction in flight.
REQ-021 d_ack while d_valid=0 SHALL be ignored.
REQ-022 gnt SHALL be high for exactly one cycle per transaction and never have more than one bit set.

Reset
REQ-023 Rst=1 at a rising edge SHALL force state=IDLE, ptr=0, op=0, id=0, gnt=0, d=0, d_id=0, d_valid=0, ovf=0.
REQ-024 Reset in BUSY or DONE SHALL abandon the transaction; no result delivered, ptr returns to 0.
REQ-025 Rst SHALL take priority over every other input in the same cycle.

Structure
REQ-026 Shared package SHALL hold NREQ, id width (2), and state encoding constants IDLE/BUSY/DONE.
REQ-027 Datapath SHALL be one instance of the existing SINC incrementer component (DATAWIDTH passed through) fed by op; FSM and arbiter logic stay in sinc_arbiter.

Verification (DATAWIDTH=8)
REQ-028 Reset, then req=0100, a2=5 -> gnt=0100 for 1 cycle, then d=6, d_id=2, d_valid=1, ovf=0 held until d_ack.
REQ-029 Reset, all four requesters request continuously (re-raising after grant), d_ack=1 -> grant order 0,1,2,3,0.
REQ-030 After serving id 1, req=1001 simultaneously -> id 3 wins; next transaction grants id 0.
REQ-031 a0=127 -> d=-128, ovf=1; a0=-1 -> d=0, ovf=0; a0=-128 -> d=-127, ovf=0.
REQ-032 d_ack low for 5 cycles with req=0010 pending -> d, d_id, d_valid stable, gnt=0 throughout; grant to id 1 only after ack.
REQ-033 Rst asserted during DONE -> next cycle d_valid=0, gnt=0, state IDLE; following req=0001 granted to id 0 from ptr 0.
